// File: rtl/frame_cfg_pkg.sv
// Shared constants, state encoding and helpers for the frame configuration writer.
package frame_cfg_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [WORD_W-1:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [WORD_W-1:0] DESYNC_WORD = 32'hFAB0_FAB0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_SETUP  = 3'd3,
    ST_STROBE = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  // Frame counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Only the word-consuming states present in_ready.
  function automatic logic accepts_word(input state_t s);
    return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Binary frame index plus enable to one-hot latch enable vector (combinational).
module frame_strobe_decoder #(
  parameter int unsigned STROBE_WIDTH = 20,
  parameter int unsigned IDX_W        = 5
) (
  input  logic [IDX_W-1:0]        index,
  input  logic                    en,
  output logic [STROBE_WIDTH-1:0] strobe
);

  always_comb begin
    strobe = '0;
    for (int i = 0; i < int'(STROBE_WIDTH); i++) begin
      strobe[i] = en && (index == IDX_W'(i));
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Bitstream word parser driving frame data and one-hot latch strobes with
// one cycle of setup before and one cycle of hold after each strobe pulse.
module frame_config_writer
  import frame_cfg_pkg::*;
#(
  parameter int unsigned FRAME_BITS    = 32,
  parameter int unsigned STROBE_WIDTH  = 20,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FRAME_BITS-1:0]   frame_data,
  output logic [STROBE_WIDTH-1:0] frame_strobe,
  output logic                    active,
  output logic                    err,
  output logic [15:0]             frames_written
);

  localparam int unsigned IDX_W  = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1;
  localparam int unsigned SCNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        index, index_nxt;
  logic [SCNT_W-1:0]       scnt, scnt_nxt;
  logic [FRAME_BITS-1:0]   frame_data_nxt;
  logic                    active_nxt, err_nxt;
  logic [CNT_W-1:0]        frames_nxt;
  logic [STROBE_WIDTH-1:0] strobe_dec;
  logic                    xfer, addr_bad, is_desync;

  assign xfer      = in_valid && in_ready;
  assign is_desync = (in_data == DESYNC_WORD);
  assign addr_bad  = (in_data[31:16] != 16'd0) || (32'(in_data[15:0]) >= STROBE_WIDTH);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (xfer && (in_data == SYNC_WORD)) state_nxt = ST_ADDR;
      ST_ADDR:   if (xfer) state_nxt = (is_desync || addr_bad) ? ST_IDLE : ST_DATA;
      ST_DATA:   if (xfer) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_STROBE;
      ST_STROBE: if (scnt == '0) state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = ST_ADDR;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and flag next values
  always_comb begin
    index_nxt      = index;
    scnt_nxt       = scnt;
    frame_data_nxt = frame_data;
    active_nxt     = active;
    err_nxt        = err;
    frames_nxt     = frames_written;
    unique case (state)
      ST_IDLE: begin
        if (xfer && (in_data == SYNC_WORD)) begin
          active_nxt = 1'b1;
          err_nxt    = 1'b0;
          frames_nxt = '0;
        end
      end
      ST_ADDR: begin
        if (xfer) begin
          if (is_desync) begin
            active_nxt = 1'b0;
          end else if (addr_bad) begin
            active_nxt = 1'b0;
            err_nxt    = 1'b1;
          end else begin
            index_nxt = IDX_W'(in_data[15:0]);
          end
        end
      end
      ST_DATA:   if (xfer) frame_data_nxt = FRAME_BITS'(in_data);
      ST_SETUP:  scnt_nxt = SCNT_W'(STROBE_CYCLES - 1);
      ST_STROBE: if (scnt != '0) scnt_nxt = scnt - SCNT_W'(1);
      ST_HOLD:   frames_nxt = sat_inc(frames_written);
      default: ;
    endcase
  end

  // Strobe is registered from the decoded next state so it is high exactly in STROBE.
  frame_strobe_decoder #(
    .STROBE_WIDTH(STROBE_WIDTH),
    .IDX_W       (IDX_W)
  ) u_dec (
    .index (index),
    .en    (state_nxt == ST_STROBE),
    .strobe(strobe_dec)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_ready       <= 1'b1;
      frame_data     <= '0;
      frame_strobe   <= '0;
      active         <= 1'b0;
      err            <= 1'b0;
      frames_written <= '0;
      index          <= '0;
      scnt           <= '0;
    end else begin
      in_ready       <= accepts_word(state_nxt);
      frame_data     <= frame_data_nxt;
      frame_strobe   <= strobe_dec;
      active         <= active_nxt;
      err            <= err_nxt;
      frames_written <= frames_nxt;
      index          <= index_nxt;
      scnt           <= scnt_nxt;
    end
  end

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed bench for frame_config_writer: cycle-accurate transaction model
// compared every cycle, plus literal expectations at key points.
module tb_frame_config_writer;

  localparam int SC = 2;
  localparam int SW = 20;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   frame_data;
  logic [SW-1:0] frame_strobe;
  logic          active;
  logic          err;
  logic [15:0]   frames_written;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  frame_config_writer #(
    .FRAME_BITS   (32),
    .STROBE_WIDTH (SW),
    .STROBE_CYCLES(SC)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .frame_data    (frame_data),
    .frame_strobe  (frame_strobe),
    .active        (active),
    .err           (err),
    .frames_written(frames_written)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 hunting, 1 expecting address, 2 expecting data.
  // m_n counts edges since a data word was taken (0 = not busy).
  int          m_mode = 0;
  int          m_n    = 0;
  logic [4:0]  m_idx  = '0;
  logic [31:0] m_fd   = '0;
  logic        m_err  = 1'b0;
  logic        m_act  = 1'b0;
  logic [15:0] m_fw   = '0;

  always @(posedge CLK) begin
    if (RST) begin
      m_mode = 0; m_n = 0; m_idx = '0; m_fd = '0;
      m_err = 1'b0; m_act = 1'b0; m_fw = '0;
    end else if (m_n > 0) begin
      if (m_n == SC + 2) begin
        m_n = 0;
        if (m_fw != 16'hFFFF) m_fw = m_fw + 16'd1;
      end else begin
        m_n = m_n + 1;
      end
    end else if (in_valid) begin
      case (m_mode)
        0: if (in_data == SYNC) begin
             m_mode = 1; m_err = 1'b0; m_fw = '0; m_act = 1'b1;
           end
        1: if (in_data == DESYNC) begin
             m_mode = 0; m_act = 1'b0;
           end else if (in_data[31:16] != 16'd0 || in_data[15:0] >= 16'(SW)) begin
             m_mode = 0; m_act = 1'b0; m_err = 1'b1;
           end else begin
             m_idx = in_data[4:0]; m_mode = 2;
           end
        default: begin
          m_fd = in_data; m_n = 1; m_mode = 1;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    logic [SW-1:0] exp_strobe;
    if (cmp_en) begin
      exp_strobe = (m_n >= 2 && m_n <= SC + 1) ? (SW'(1) << m_idx) : '0;
      chk("m_ready",  32'(in_ready),       32'(m_n == 0));
      chk("m_data",   frame_data,          m_fd);
      chk("m_strobe", 32'(frame_strobe),   32'(exp_strobe));
      chk("m_active", 32'(active),         32'(m_act));
      chk("m_err",    32'(err),            32'(m_err));
      chk("m_frames", 32'(frames_written), 32'(m_fw));
    end
  end

  // Present a word after 'gap' idle cycles; returns at the negedge after it is consumed.
  task automatic send(input logic [31:0] w, input int gap);
    int k;
    in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    in_data  = w;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: word %h not accepted within 100 cycles", w);
      in_valid = 1'b0;
    end else begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready",  32'(in_ready), 32'd1);
    chk("rst_data",   frame_data, 32'd0);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_frames", 32'(frames_written), 32'd0);
    RST = 1'b0;
    cmp_en = 1'b1;

    // Basic frame: addr 3, data DEADBEEF.
    send(SYNC, 0);
    send(32'h0000_0003, 0);
    send(32'hDEAD_BEEF, 0);
    chk("t1_setup_data",   frame_data, 32'hDEAD_BEEF);
    chk("t1_setup_strobe", 32'(frame_strobe), 32'd0);
    @(negedge CLK); chk("t1_strobe_c1", 32'(frame_strobe), 32'h0000_0008);
    @(negedge CLK); chk("t1_strobe_c2", 32'(frame_strobe), 32'h0000_0008);
    @(negedge CLK); chk("t1_hold_strobe", 32'(frame_strobe), 32'd0);
                    chk("t1_hold_ready",  32'(in_ready), 32'd0);
    @(negedge CLK); chk("t1_ready_back",  32'(in_ready), 32'd1);
                    chk("t1_frames",      32'(frames_written), 32'd1);
    send(DESYNC, 1);
    chk("t1_desync_active", 32'(active), 32'd0);

    // Junk in IDLE is discarded.
    send(32'h1234_5678, 0);
    send(DESYNC, 1);
    chk("junk_active", 32'(active), 32'd0);
    chk("junk_data",   frame_data, 32'hDEAD_BEEF);

    // Out-of-range addresses set err and drop sync; next SYNC clears it.
    send(SYNC, 0);
    send(32'd20, 0);
    chk("bad20_err",    32'(err), 32'd1);
    chk("bad20_active", 32'(active), 32'd0);
    send(32'h0000_0005, 2);
    chk("bad20_idle_err", 32'(err), 32'd1);
    send(SYNC, 0);
    chk("resync_err",    32'(err), 32'd0);
    chk("resync_active", 32'(active), 32'd1);
    send(32'h0001_0000, 0);
    chk("badhi_err", 32'(err), 32'd1);
    send(SYNC, 1);

    // Three frames with irregular valid, then DESYNC.
    send(32'd0,          $urandom_range(0, 2));
    send(32'h1111_1111,  $urandom_range(0, 2));
    send(32'd19,         0);
    send(32'hA5A5_A5A5,  $urandom_range(0, 2));
    send(32'd10,         0);
    send(32'h0F0F_0F0F,  $urandom_range(0, 2));
    send(DESYNC,         0);
    chk("three_frames", 32'(frames_written), 32'd3);
    chk("three_active", 32'(active), 32'd0);
    chk("three_data",   frame_data, 32'h0F0F_0F0F);

    // DESYNC value in the data slot is plain frame data.
    send(SYNC, 0);
    send(32'd7, 0);
    send(DESYNC, 0);
    chk("dsdata_data",   frame_data, DESYNC);
    chk("dsdata_active", 32'(active), 32'd1);
    @(negedge CLK); chk("dsdata_strobe", 32'(frame_strobe), 32'h0000_0080);

    // Reset in the second strobe cycle.
    send(32'd9, 0);
    send(32'hCAFE_F00D, 0);
    @(negedge CLK);
    @(negedge CLK); chk("rst_mid_strobe_on", 32'(frame_strobe), 32'h0000_0200);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_strobe",  32'(frame_strobe), 32'd0);
    chk("rst_mid_ready",   32'(in_ready), 32'd1);
    chk("rst_mid_data",    frame_data, 32'd0);
    chk("rst_mid_active",  32'(active), 32'd0);
    chk("rst_mid_frames",  32'(frames_written), 32'd0);
    RST = 1'b0;

    // Replay after reset.
    send(SYNC, 1);
    send(32'd19, 0);
    send(32'h5555_AAAA, 0);
    repeat (SC + 3) @(negedge CLK);
    chk("replay_frames", 32'(frames_written), 32'd1);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
